// File: rtl/u2_to_onehot_encoder.sv
// Streaming signed-position to one-hot {B,A} encoder with a 2-entry output buffer.
// Optional macro ONEHOT_ENC_STATS_EN adds o_bad_cnt, a saturating count of err/overflow pushes.
module u2_to_onehot_encoder #(
   parameter int LEN   = 8,
   parameter int WIDTH = 6
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_pos_u2,
   input  logic             i_valid,
   output logic             o_ready,
   output logic [LEN-1:0]   o_a_oh,
   output logic [LEN-1:0]   o_b_oh,
   output logic             o_overflow,
   output logic             o_err,
   output logic             o_valid,
   input  logic             i_ready
`ifdef ONEHOT_ENC_STATS_EN
   ,
   output logic [7:0]       o_bad_cnt
`endif
);

   localparam int VLEN = LEN + LEN;
   localparam int EW   = VLEN + 2;
   localparam logic [WIDTH-1:0] MAX_POS = WIDTH'(VLEN - 1);

   typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

   occ_t            state_reg, state_next;
   logic            push, pop;
   logic            load_head_new, load_head_tail, load_tail;
   logic            enc_err, enc_ovf;
   logic [VLEN-1:0] enc_vec;
   logic [EW-1:0]   enc_entry;
   logic [EW-1:0]   head_reg, tail_reg;
   logic [EW-1:0]   head_out;

   // Entry layout: {vector[VLEN-1:0], overflow, err}
   assign enc_err = i_pos_u2[WIDTH-1];
   assign enc_ovf = !enc_err && (i_pos_u2 > MAX_POS);

   genvar gi;
   generate
      for (gi = 0; gi < VLEN; gi++) begin : g_onehot
         assign enc_vec[gi] = !enc_err && (i_pos_u2 == WIDTH'(gi));
      end
   endgenerate

   assign enc_entry = {enc_vec, enc_ovf, enc_err};

   assign o_ready = (state_reg != TWO);
   assign o_valid = (state_reg != EMPTY);
   assign push    = i_valid & o_ready;
   assign pop     = o_valid & i_ready;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg <= EMPTY;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      load_head_new  = 1'b0;
      load_head_tail = 1'b0;
      load_tail      = 1'b0;
      case (state_reg)
         EMPTY: begin
            if (push) begin
               load_head_new = 1'b1;
               state_next    = ONE;
            end
         end
         ONE: begin
            case ({push, pop})
               2'b10: begin
                  load_tail  = 1'b1;
                  state_next = TWO;
               end
               2'b01: state_next = EMPTY;
               2'b11: load_head_new = 1'b1;
               default: state_next = ONE;
            endcase
         end
         TWO: begin
            if (pop) begin
               load_head_tail = 1'b1;
               state_next     = ONE;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         head_reg <= '0;
         tail_reg <= '0;
      end else begin
         if (load_head_new) begin
            head_reg <= enc_entry;
         end else if (load_head_tail) begin
            head_reg <= tail_reg;
         end
         if (load_tail) begin
            tail_reg <= enc_entry;
         end
      end
   end

   // A popped-to-empty head keeps stale contents, so gate outputs on occupancy.
   assign head_out   = o_valid ? head_reg : '0;
   assign o_b_oh     = head_out[EW-1 -: LEN];
   assign o_a_oh     = head_out[2 +: LEN];
   assign o_overflow = head_out[1];
   assign o_err      = head_out[0];

`ifdef ONEHOT_ENC_STATS_EN
   logic [7:0] bad_cnt_reg;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         bad_cnt_reg <= 8'd0;
      end else if (push && (enc_err || enc_ovf) && (bad_cnt_reg != 8'hFF)) begin
         bad_cnt_reg <= bad_cnt_reg + 8'd1;
      end
   end

   assign o_bad_cnt = bad_cnt_reg;
`endif

endmodule

// File: tb/tb_u2_to_onehot_encoder.sv
// Scoreboard bench for u2_to_onehot_encoder: driver queues expected entries, a negedge monitor pops and compares.
module tb_u2_to_onehot_encoder;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] i_pos;
   logic       i_valid;
   logic       o_ready;
   logic [7:0] o_a_oh;
   logic [7:0] o_b_oh;
   logic       o_overflow;
   logic       o_err;
   logic       o_valid;
   logic       i_ready;
`ifdef ONEHOT_ENC_STATS_EN
   logic [7:0] o_bad_cnt;
`endif

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       err;
      logic       ovf;
      int         pos;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   stalls   = 0;
   int   bad_exp  = 0;
   int   cyc      = 0;

   u2_to_onehot_encoder #(.LEN(8), .WIDTH(6)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_pos_u2   (i_pos),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .o_a_oh     (o_a_oh),
      .o_b_oh     (o_b_oh),
      .o_overflow (o_overflow),
      .o_err      (o_err),
      .o_valid    (o_valid),
      .i_ready    (i_ready)
`ifdef ONEHOT_ENC_STATS_EN
      ,
      .o_bad_cnt  (o_bad_cnt)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: a head presented with i_ready=1 is consumed at the next rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (o_valid && i_ready) begin
               if (sb.size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_output: got a=%0h b=%0h expected none", o_a_oh, o_b_oh);
               end else begin
                  e = sb.pop_front();
                  check($sformatf("a_oh p=%0d", e.pos), 32'(o_a_oh), 32'(e.a));
                  check($sformatf("b_oh p=%0d", e.pos), 32'(o_b_oh), 32'(e.b));
                  check($sformatf("err p=%0d", e.pos), 32'(o_err), 32'(e.err));
                  check($sformatf("ovf p=%0d", e.pos), 32'(o_overflow), 32'(e.ovf));
                  $display("pop  p=%0d a=%02h b=%02h err=%0b ovf=%0b", e.pos, o_a_oh, o_b_oh, o_err, o_overflow);
               end
            end
            if (!o_valid) check("idle_zero", {14'd0, o_a_oh, o_b_oh, o_err, o_overflow}, 32'd0);
         end
      end
   end

   // Driver: holds the word until accepted, queues its hand-computed expectation at the accepting edge.
   task automatic send(input logic [5:0] p, input logic [7:0] ea, input logic [7:0] eb,
                       input logic ee, input logic eo);
      exp_t e;
      int   w;
      i_valid = 1'b1;
      i_pos   = p;
      w       = 0;
      @(negedge clk);
      while (!o_ready && w < 50) begin
         w++;
         @(negedge clk);
      end
      stalls += w;
      if (w >= 50) begin
         n_checks++;
         $display("FAIL push_timeout: got o_ready=0 for 50 cycles expected 1 (p=%0d)", $signed(p));
      end else begin
         e.a = ea; e.b = eb; e.err = ee; e.ovf = eo; e.pos = int'($signed(p));
         sb.push_back(e);
         if (ee || eo) bad_exp++;
         $display("push p=%0d exp a=%02h b=%02h err=%0b ovf=%0b", $signed(p), ea, eb, ee, eo);
      end
      @(posedge clk);
      #1;
      i_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int k;
      k = 0;
      while (sb.size() != 0 && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
      end
   endtask

   task automatic check_stats(input string name);
`ifdef ONEHOT_ENC_STATS_EN
      check(name, 32'(o_bad_cnt), 32'(bad_exp));
`else
      if (name.len() == 0) $display("stats check skipped");
`endif
   endtask

   initial begin
      int t0;
      rst     = 1'b1;
      i_valid = 1'b0;
      i_pos   = 6'd0;
      i_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_ready", 32'(o_ready), 32'd1);
      check("rst_data", {14'd0, o_a_oh, o_b_oh, o_err, o_overflow}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Basic encodings and boundaries
      send(6'd0, 8'h01, 8'h00, 1'b0, 1'b0);
      check("latency_valid", 32'(o_valid), 32'd1);
      check("latency_a", 32'(o_a_oh), 32'h01);
      send(6'd11, 8'h00, 8'h08, 1'b0, 1'b0);
      send(6'd15, 8'h00, 8'h80, 1'b0, 1'b0);
      send(6'h3F, 8'h00, 8'h00, 1'b1, 1'b0);
      send(6'd16, 8'h00, 8'h00, 1'b0, 1'b1);
      check_stats("bad_cnt_2");
      send(6'd7,  8'h80, 8'h00, 1'b0, 1'b0);
      send(6'd8,  8'h00, 8'h01, 1'b0, 1'b0);
      send(6'h1F, 8'h00, 8'h00, 1'b0, 1'b1);
      send(6'h20, 8'h00, 8'h00, 1'b1, 1'b0);
      check_stats("bad_cnt_4");
      wait_drain("basic");

      // Backpressure fills both slots
      i_ready = 1'b0;
      send(6'd3, 8'h08, 8'h00, 1'b0, 1'b0);
      send(6'd5, 8'h20, 8'h00, 1'b0, 1'b0);
      check("bp_ready_low", 32'(o_ready), 32'd0);
      check("bp_head", 32'(o_a_oh), 32'h08);
      repeat (3) @(posedge clk);
      #1;
      check("bp_hold_valid", 32'(o_valid), 32'd1);
      check("bp_hold_head", 32'(o_a_oh), 32'h08);
      i_ready = 1'b1;
      wait_drain("bp");
      check("bp_ready_back", 32'(o_ready), 32'd1);
      check("bp_empty", 32'(o_valid), 32'd0);

      // Continuous stream: push and pop in the same cycle
      stalls = 0;
      t0 = cyc;
      for (int p = 0; p < 16; p++) begin
         send(6'(p), (p < 8) ? 8'(1 << p) : 8'h00, (p >= 8) ? 8'(1 << (p - 8)) : 8'h00, 1'b0, 1'b0);
      end
      check("stream_stalls", 32'(stalls), 32'd0);
      check("stream_cycles", 32'(cyc - t0), 32'd16);
      wait_drain("stream");

      // Asynchronous reset with two entries held
      i_ready = 1'b0;
      send(6'd7, 8'h80, 8'h00, 1'b0, 1'b0);
      send(6'd9, 8'h00, 8'h02, 1'b0, 1'b0);
      check("pre_rst_full", 32'(o_ready), 32'd0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", 32'(o_valid), 32'd0);
      check("arst_data", {14'd0, o_a_oh, o_b_oh, o_err, o_overflow}, 32'd0);
      check("arst_ready", 32'(o_ready), 32'd1);
      sb.delete();
      bad_exp = 0;
      @(negedge clk);
      rst     = 1'b0;
      i_ready = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_ready", 32'(o_ready), 32'd1);
      check_stats("bad_cnt_cleared");
      send(6'd2, 8'h04, 8'h00, 1'b0, 1'b0);
      check("post_rst_head", 32'(o_a_oh), 32'h04);
      wait_drain("post_rst");
      repeat (2) @(posedge clk);
      #1;
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
